digit_result_controller: RTL and testbench
==========================================

Name: digit_result_controller

Overview:
Sequences the single-byte predicted-digit RAM. On each inference completion it writes the digit, reads it back, and streams an ASCII report ("D", digit, CR, LF) to the UART transmitter over a valid/ready handshake. It also arbitrates the RAM read port for the 7-segment display requester. It sits between the CNN inference core, the predicted-digit RAM, the UART TX and the display driver.

Parameters:
HDR_CHAR, 8'h44, header byte sent before the digit ('D')
SEND_CRLF, 1, 1 = append 8'h0D, 8'h0A after the digit; 0 = header and digit only
DROP_W, 8, width of the dropped-result counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
inference_done  in  1  one-cycle pulse: predicted_digit is valid
predicted_digit  in  4  inference result (0-9 nominal)
ram_wr_en  out  1  RAM write enable
ram_wr_data  out  4  RAM write data
ram_rd_addr  out  1  RAM read address, tied 0
ram_rd_data  in  8  RAM registered read data; digit in [3:0]
tx_data  out  8  ASCII byte to UART
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART accepts byte
disp_req  in  1  display requests current digit (level)
disp_valid  out  1  one-cycle pulse: disp_digit is updated
disp_digit  out  4  digit read for the display
busy  out  1  high in any state except IDLE
drop_count  out  DROP_W  saturating count of inference_done pulses ignored while busy

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; ram_wr_en=0, ram_wr_data=0, tx_valid=0, tx_data=0, disp_valid=0, disp_digit=0, drop_count=0, busy=0. RAM contents are not cleared. Reset mid-transfer abandons the frame; tx_valid is 0 from the cycle after the reset edge.
- All outputs are registered. ram_rd_addr is constant 0.
- States: IDLE, WRITE, RD_ISSUE, RD_CAP, TX_HDR, TX_DIG, TX_CR, TX_LF, DISP_RD, DISP_CAP.
- IDLE, inference_done=1 in cycle T: latch predicted_digit, go to WRITE. In T+1, ram_wr_en=1 and ram_wr_data=latched digit, for exactly one cycle.
- T+2 RD_ISSUE: no action (RAM read latency). T+3 RD_CAP: capture ram_rd_data as the report byte source, which must equal the written digit.
- Digit encoding: if ram_rd_data[7:4]==0 and [3:0]<=9, send 8'h30+digit; otherwise send 8'h3F ('?').
- TX_HDR, TX_DIG, TX_CR, TX_LF: tx_valid=1 from the first cycle of the state, with tx_data stable.
  - Advance only on a cycle where tx_valid&&tx_ready.
  - tx_valid deasserts the cycle after the last accepted byte, unless the next byte follows immediately; back-to-back bytes are allowed.
  - With SEND_CRLF=0, go from TX_DIG to IDLE.
  - After the final accepted byte, return to IDLE.
- Minimum frame (tx_ready tied 1): first tx_valid in T+4, 4 bytes in T+4..T+7, IDLE at T+8.
- Display arbitration: in IDLE with disp_req=1 and inference_done=0 at cycle T, go to DISP_RD (T+1), then DISP_CAP (T+2). disp_digit<=ram_rd_data[3:0] and disp_valid=1 in T+3 for one cycle. Return to IDLE in T+3.
- Simultaneous inference_done and disp_req in IDLE: inference wins. The display is served on a later IDLE cycle if disp_req is still high.
- disp_req while busy: no action, no error. The request is held off until IDLE.
- inference_done while busy (any non-IDLE state): the digit is discarded, RAM is not written, and drop_count increments, saturating at all-ones.
- tx_ready stuck low: remain in the TX state indefinitely with tx_valid held. No timeout.

Decomposition:
- Shared package: state enum encoding, ASCII constants (CHAR_ZERO 8'h30, CHAR_QMARK 8'h3F, CHAR_CR 8'h0D, CHAR_LF 8'h0A), and the digit-to-ASCII function.
- One natural sub-module: digit_ascii_tx_seq, covering the TX_HDR..TX_LF byte sequencer and the valid/ready handshake. The main FSM hands it a start pulse and a byte, and receives a done pulse.

Test Plan:
1. Reset, then inference_done with digit 7, tx_ready=1 -> ram_wr_en for 1 cycle with data 7 at T+1; bytes 0x44,0x37,0x0D,0x0A on T+4..T+7; busy low at T+8; drop_count=0.
2. Digit 3 with tx_ready toggling 1/0 each cycle -> same 4 bytes, each held stable until accepted, no duplicates or losses.
3. Second inference_done (digit 5) during TX_DIG of digit 2 -> report is "D2\r\n" only; RAM still holds 2; drop_count=1. Hold 300 extra pulses during a stalled frame (DROP_W=8) -> drop_count=255.
4. disp_req with inference_done in the same cycle (digit 9), disp_req held -> frame "D9\r\n" completes, then disp_valid pulse with disp_digit=9 three cycles after the following IDLE cycle.
5. Force predicted_digit=4'hC -> digit byte 0x3F. With SEND_CRLF=0 -> only 2 bytes sent.
6. Assert rst during TX_CR with tx_ready=0 -> tx_valid=0 the next cycle, state IDLE, drop_count=0. A following inference works normally.

Source files
------------

// File: rtl/digit_result_controller_pkg.sv
// Shared types and constants for the predicted-digit result controller.
// Holds the controller state encoding, ASCII constants and the digit-to-ASCII mapping.
package digit_result_controller_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_CAP,
    TX_HDR,
    TX_DIG,
    TX_CR,
    TX_LF,
    DISP_RD,
    DISP_CAP
  } state_t;

  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_QMARK = 8'h3F;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  // Anything outside 0..9, including stray upper-nibble bits, reports as '?'.
  function automatic logic [7:0] digit_to_ascii(input logic [7:0] rd);
    if (rd[7:4] == 4'h0 && rd[3:0] <= 4'd9)
      return CHAR_ZERO + {4'h0, rd[3:0]};
    else
      return CHAR_QMARK;
  endfunction

endpackage

// File: rtl/digit_result_controller_if.sv
// Byte stream handshake from the result controller to the UART transmitter.
interface digit_result_controller_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/digit_ascii_tx_seq.sv
// Sends header, digit and optional CR/LF over a valid/ready handshake.
// done is combinational on the final accepted byte so the caller can return to IDLE on the next edge.
module digit_ascii_tx_seq
  import digit_result_controller_pkg::*;
#(
  parameter logic [7:0] HDR_CHAR  = 8'h44,
  parameter int         SEND_CRLF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] digit_byte,
  output logic       done,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  state_t     seq_q, seq_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [7:0] dig_q, dig_d;
  logic       accept;

  assign accept   = valid_q && tx_ready;
  assign tx_data  = data_q;
  assign tx_valid = valid_q;

  always_comb begin
    seq_d   = seq_q;
    data_d  = data_q;
    valid_d = valid_q;
    dig_d   = dig_q;
    done    = 1'b0;
    case (seq_q)
      IDLE: begin
        if (start) begin
          seq_d   = TX_HDR;
          valid_d = 1'b1;
          data_d  = HDR_CHAR;
          dig_d   = digit_byte;
        end
      end
      TX_HDR: begin
        if (accept) begin
          seq_d  = TX_DIG;
          data_d = dig_q;
        end
      end
      TX_DIG: begin
        if (accept) begin
          if (SEND_CRLF != 0) begin
            seq_d  = TX_CR;
            data_d = CHAR_CR;
          end else begin
            seq_d   = IDLE;
            valid_d = 1'b0;
            done    = 1'b1;
          end
        end
      end
      TX_CR: begin
        if (accept) begin
          seq_d  = TX_LF;
          data_d = CHAR_LF;
        end
      end
      TX_LF: begin
        if (accept) begin
          seq_d   = IDLE;
          valid_d = 1'b0;
          done    = 1'b1;
        end
      end
      default: begin
        seq_d   = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q   <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      dig_q   <= '0;
    end else begin
      seq_q   <= seq_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      dig_q   <= dig_d;
    end
  end

endmodule

// File: rtl/digit_result_controller.sv
// Writes each inference result to the digit RAM, reads it back, reports it over UART,
// and serves display read requests from IDLE.
module digit_result_controller
  import digit_result_controller_pkg::*;
#(
  parameter logic [7:0] HDR_CHAR  = 8'h44,
  parameter int         SEND_CRLF = 1,
  parameter int         DROP_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inference_done,
  input  logic [3:0]                 predicted_digit,
  output logic                       ram_wr_en,
  output logic [3:0]                 ram_wr_data,
  output logic                       ram_rd_addr,
  input  logic [7:0]                 ram_rd_data,
  digit_result_controller_if.master  tx,
  input  logic                       disp_req,
  output logic                       disp_valid,
  output logic [3:0]                 disp_digit,
  output logic                       busy,
  output logic [DROP_W-1:0]          drop_count
);

  state_t            state_q, state_d;
  logic              seq_start, seq_done;
  logic [7:0]        seq_data;
  logic              seq_valid;
  logic              wr_en_q, disp_valid_q, busy_q;
  logic [3:0]        wr_data_q, disp_digit_q;
  logic [DROP_W-1:0] drop_q;

  assign ram_rd_addr = 1'b0;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_data = wr_data_q;
  assign disp_valid  = disp_valid_q;
  assign disp_digit  = disp_digit_q;
  assign busy        = busy_q;
  assign drop_count  = drop_q;
  assign tx.tx_data  = seq_data;
  assign tx.tx_valid = seq_valid;

  // The whole byte sequence lives in the sequencer; this FSM parks in TX_HDR until done.
  always_comb begin
    state_d   = state_q;
    seq_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (inference_done)
          state_d = WRITE;
        else if (disp_req)
          state_d = DISP_RD;
      end
      WRITE:    state_d = RD_ISSUE;
      RD_ISSUE: state_d = RD_CAP;
      RD_CAP: begin
        seq_start = 1'b1;
        state_d   = TX_HDR;
      end
      TX_HDR, TX_DIG, TX_CR, TX_LF: begin
        if (seq_done) state_d = IDLE;
      end
      DISP_RD:  state_d = DISP_CAP;
      DISP_CAP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      disp_valid_q <= 1'b0;
      disp_digit_q <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != IDLE);
      wr_en_q      <= (state_q == IDLE) && inference_done;
      disp_valid_q <= (state_q == DISP_CAP);
      if (state_q == IDLE && inference_done)
        wr_data_q <= predicted_digit;
      if (state_q == DISP_CAP)
        disp_digit_q <= ram_rd_data[3:0];
      if (state_q != IDLE && inference_done && drop_q != '1)
        drop_q <= drop_q + DROP_W'(1);
    end
  end

  digit_ascii_tx_seq #(
    .HDR_CHAR  (HDR_CHAR),
    .SEND_CRLF (SEND_CRLF)
  ) u_tx_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (seq_start),
    .digit_byte (digit_to_ascii(ram_rd_data)),
    .done       (seq_done),
    .tx_data    (seq_data),
    .tx_valid   (seq_valid),
    .tx_ready   (tx.tx_ready)
  );

endmodule

// File: tb/tb_digit_result_controller.sv
// Bench for digit_result_controller: RAM model, UART byte scoreboard, scenario tasks.
module tb_digit_result_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       inference_done = 1'b0, inference_done2 = 1'b0;
  logic       disp_req = 1'b0, disp_req2 = 1'b0;
  logic [3:0] predicted_digit = 4'h0;

  logic       ram_wr_en, ram_wr_en2, ram_rd_addr, ram_rd_addr2;
  logic [3:0] ram_wr_data, ram_wr_data2, disp_digit, disp_digit2;
  logic       disp_valid, disp_valid2, busy, busy2;
  logic [7:0] drop_count, drop_count2;

  logic [7:0] mem1 = 8'h00, mem2 = 8'h00, rd1 = 8'h00, rd2 = 8'h00;

  digit_result_controller_if tx_if ();
  digit_result_controller_if tx_if2 ();

  digit_result_controller #(.HDR_CHAR(8'h44), .SEND_CRLF(1), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .inference_done(inference_done), .predicted_digit(predicted_digit),
    .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(rd1),
    .tx(tx_if), .disp_req(disp_req), .disp_valid(disp_valid), .disp_digit(disp_digit),
    .busy(busy), .drop_count(drop_count));

  digit_result_controller #(.HDR_CHAR(8'h44), .SEND_CRLF(0), .DROP_W(8)) dut2 (
    .clk(clk), .rst(rst), .inference_done(inference_done2), .predicted_digit(predicted_digit),
    .ram_wr_en(ram_wr_en2), .ram_wr_data(ram_wr_data2), .ram_rd_addr(ram_rd_addr2), .ram_rd_data(rd2),
    .tx(tx_if2), .disp_req(disp_req2), .disp_valid(disp_valid2), .disp_digit(disp_digit2),
    .busy(busy2), .drop_count(drop_count2));

  // Single-byte RAM with registered read
  always @(posedge clk) begin
    if (ram_wr_en)  mem1 <= {4'h0, ram_wr_data};
    if (ram_wr_en2) mem2 <= {4'h0, ram_wr_data2};
    rd1 <= mem1;
    rd2 <= mem2;
  end

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$], exp_q2[$];
  logic [7:0] hold_data = 8'h00, e;
  logic       hold_pend = 1'b0;

  // Scoreboard: every accepted byte is popped and compared; stalled bytes must stay put.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_cmp++;
        if (!(tx_if.tx_valid === 1'b1 && tx_if.tx_data === hold_data)) begin
          n_bad++;
          $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                   tx_if.tx_valid, tx_if.tx_data, hold_data);
        end
      end
      if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL tx_byte: got unexpected %h, required no byte", tx_if.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_if.tx_data !== e) begin
            n_bad++;
            $display("FAIL tx_byte: got %h, required %h", tx_if.tx_data, e);
          end
        end
        hold_pend = 1'b0;
      end else begin
        hold_pend = (tx_if.tx_valid === 1'b1);
        hold_data = tx_if.tx_data;
      end
      if (tx_if2.tx_valid === 1'b1 && tx_if2.tx_ready === 1'b1) begin
        n_cmp++;
        if (exp_q2.size() == 0) begin
          n_bad++;
          $display("FAIL tx2_byte: got unexpected %h, required no byte", tx_if2.tx_data);
        end else begin
          e = exp_q2.pop_front();
          if (tx_if2.tx_data !== e) begin
            n_bad++;
            $display("FAIL tx2_byte: got %h, required %h", tx_if2.tx_data, e);
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [7:0] dch);
    exp_q.push_back(8'h44); exp_q.push_back(dch);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_if.tx_ready = 1'b1;
    tx_if2.tx_ready = 1'b1;
    step(3);
    @(negedge clk);
    n_cmp++;
    if ({busy, tx_if.tx_valid, ram_wr_en, disp_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got busy/valid/wr/disp=%b, required 0000",
               {busy, tx_if.tx_valid, ram_wr_en, disp_valid});
    end
    n_cmp++;
    if ({tx_if.tx_data, ram_wr_data, disp_digit, drop_count, ram_rd_addr} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_data: got tx=%h wr=%h disp=%h drop=%0d addr=%b, required all 0",
               tx_if.tx_data, ram_wr_data, disp_digit, drop_count, ram_rd_addr);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    step();
    inference_done = 1'b1; predicted_digit = 4'd7; push_frame(8'h37);
    step(); inference_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!(ram_wr_en === 1'b1 && ram_wr_data === 4'd7 && busy === 1'b1)) begin
      n_bad++;
      $display("FAIL write_cycle: got wr_en=%b data=%h busy=%b, required 1 7 1", ram_wr_en, ram_wr_data, busy);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (ram_wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL write_once: got wr_en=%b at T+2, required 0", ram_wr_en);
    end
    step(2);
    @(negedge clk);
    n_cmp++;
    if (!(tx_if.tx_valid === 1'b1 && tx_if.tx_data === 8'h44)) begin
      n_bad++;
      $display("FAIL first_byte_T4: got valid=%b data=%h, required 1 44", tx_if.tx_valid, tx_if.tx_data);
    end
    step(4);
    @(negedge clk);
    n_cmp++;
    if (!(busy === 1'b0 && tx_if.tx_valid === 1'b0 && exp_q.size() == 0 && drop_count === 8'd0)) begin
      n_bad++;
      $display("FAIL idle_T8: got busy=%b valid=%b pending=%0d drop=%0d, required 0 0 0 0",
               busy, tx_if.tx_valid, exp_q.size(), drop_count);
    end
  endtask

  task automatic test_ready_toggle();
    int cyc;
    step();
    inference_done = 1'b1; predicted_digit = 4'd3; push_frame(8'h33);
    step(); inference_done = 1'b0;
    cyc = 0;
    while (cyc < 60) begin
      tx_if.tx_ready = ~tx_if.tx_ready;
      @(negedge clk);
      if (busy === 1'b0) break;
      step();
      cyc++;
    end
    tx_if.tx_ready = 1'b1;
    n_cmp++;
    if (!(busy === 1'b0 && exp_q.size() == 0)) begin
      n_bad++;
      $display("FAIL toggle_frame: got busy=%b pending=%0d after %0d cycles, required 0 0", busy, exp_q.size(), cyc);
    end
  endtask

  task automatic test_drop();
    int cyc;
    step();
    inference_done = 1'b1; predicted_digit = 4'd2; push_frame(8'h32);
    step(); inference_done = 1'b0;
    step(4);
    inference_done = 1'b1; predicted_digit = 4'd5;
    step(); inference_done = 1'b0;
    step(2);
    @(negedge clk);
    n_cmp++;
    if (!(busy === 1'b0 && exp_q.size() == 0 && drop_count === 8'd1 && mem1 === 8'h02)) begin
      n_bad++;
      $display("FAIL drop_one: got busy=%b pending=%0d drop=%0d ram=%h, required 0 0 1 02",
               busy, exp_q.size(), drop_count, mem1);
    end
    tx_if.tx_ready = 1'b0;
    step();
    inference_done = 1'b1; predicted_digit = 4'd1; push_frame(8'h31);
    step(); inference_done = 1'b0;
    step(3);
    inference_done = 1'b1; predicted_digit = 4'd5;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 10) begin
        @(negedge clk);
        n_cmp++;
        if (drop_count !== 8'd11) begin
          n_bad++;
          $display("FAIL drop_count_incr: got %0d, required 11", drop_count);
        end
      end
    end
    inference_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!(drop_count === 8'd255 && tx_if.tx_valid === 1'b1 && tx_if.tx_data === 8'h44 && mem1 === 8'h01)) begin
      n_bad++;
      $display("FAIL drop_saturate: got drop=%0d valid=%b data=%h ram=%h, required 255 1 44 01",
               drop_count, tx_if.tx_valid, tx_if.tx_data, mem1);
    end
    tx_if.tx_ready = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (busy === 1'b0) break;
      step();
      cyc++;
    end
    n_cmp++;
    if (!(busy === 1'b0 && exp_q.size() == 0)) begin
      n_bad++;
      $display("FAIL stalled_frame_end: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_disp_collision();
    step();
    inference_done = 1'b1; disp_req = 1'b1; predicted_digit = 4'd9; push_frame(8'h39);
    step(); inference_done = 1'b0;
    step(3);
    @(negedge clk);
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL disp_during_frame: got disp_valid=%b, required 0", disp_valid);
    end
    step(4);
    @(negedge clk);
    n_cmp++;
    if (!(busy === 1'b0 && exp_q.size() == 0)) begin
      n_bad++;
      $display("FAIL collision_frame: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
    step(); disp_req = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL disp_early: got disp_valid=%b at IDLE+2, required 0", disp_valid);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (!(disp_valid === 1'b1 && disp_digit === 4'd9 && busy === 1'b0)) begin
      n_bad++;
      $display("FAIL disp_pulse: got valid=%b digit=%h busy=%b, required 1 9 0", disp_valid, disp_digit, busy);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL disp_one_cycle: got disp_valid=%b, required 0", disp_valid);
    end
  endtask

  task automatic test_qmark_nocrlf();
    step();
    inference_done = 1'b1; inference_done2 = 1'b1; predicted_digit = 4'hC;
    push_frame(8'h3F);
    exp_q2.push_back(8'h44); exp_q2.push_back(8'h3F);
    step(); inference_done = 1'b0; inference_done2 = 1'b0;
    step(5);
    @(negedge clk);
    n_cmp++;
    if (!(busy2 === 1'b0 && tx_if2.tx_valid === 1'b0 && exp_q2.size() == 0)) begin
      n_bad++;
      $display("FAIL nocrlf_frame: got busy=%b valid=%b pending=%0d, required 0 0 0",
               busy2, tx_if2.tx_valid, exp_q2.size());
    end
    step(2);
    @(negedge clk);
    n_cmp++;
    if (!(busy === 1'b0 && exp_q.size() == 0)) begin
      n_bad++;
      $display("FAIL qmark_frame: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    step();
    inference_done = 1'b1; predicted_digit = 4'd6; push_frame(8'h36);
    step(); inference_done = 1'b0;
    step(5);
    tx_if.tx_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!(tx_if.tx_valid === 1'b1 && tx_if.tx_data === 8'h0D)) begin
      n_bad++;
      $display("FAIL in_tx_cr: got valid=%b data=%h, required 1 0D", tx_if.tx_valid, tx_if.tx_data);
    end
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!(tx_if.tx_valid === 1'b0 && busy === 1'b0 && drop_count === 8'd0 && ram_wr_en === 1'b0)) begin
      n_bad++;
      $display("FAIL reset_mid: got valid=%b busy=%b drop=%0d wr=%b, required 0 0 0 0",
               tx_if.tx_valid, busy, drop_count, ram_wr_en);
    end
    tx_if.tx_ready = 1'b1;
    step();
    inference_done = 1'b1; predicted_digit = 4'd8; push_frame(8'h38);
    step(); inference_done = 1'b0;
    step(7);
    @(negedge clk);
    n_cmp++;
    if (!(busy === 1'b0 && exp_q.size() == 0 && mem1 === 8'h08)) begin
      n_bad++;
      $display("FAIL after_reset_frame: got busy=%b pending=%0d ram=%h, required 0 0 08",
               busy, exp_q.size(), mem1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ready_toggle();
    test_drop();
    test_disp_collision();
    test_qmark_nocrlf();
    test_reset_mid();
    step(2);
    n_cmp++;
    if (exp_q2.size() != 0 || busy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL dut2_final: got pending=%0d busy=%b, required 0 0", exp_q2.size(), busy2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
